spike_count_decoder: RTL

Output-side decoder for the spiking network: samples a spike vector (typically layer-2 spike outputs) over a programmable window, accumulates a saturating spike count per neuron, then sequentially scans the counts to find the most active neuron. The result is presented on a valid/ready handshake to downstream classification or host logic. It performs the spike-to-value conversion that is the reverse of the network's value-to-spike path.

---
 rtl/spike_count_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spike_count_decoder.sv
// rtl/spike_count_decoder.sv - windowed per-neuron spike counter with sequential argmax scan
module spike_count_decoder #(
   parameter int NUM_NEURONS  = 4,
   parameter int COUNT_WIDTH  = 8,
   parameter int WINDOW_WIDTH = 16,
   parameter int INDEX_WIDTH  = 2
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic                               i_start,
   input  logic [WINDOW_WIDTH-1:0]            i_window_length,
   input  logic [NUM_NEURONS-1:0]             i_spike_in,
   output logic                               o_busy,
   output logic                               o_out_valid,
   input  logic                               i_out_ready,
   output logic [NUM_NEURONS*COUNT_WIDTH-1:0] o_spike_counts,
   output logic [NUM_NEURONS-1:0]             o_saturated,
   output logic [INDEX_WIDTH-1:0]             o_winner_index,
   output logic                               o_any_spike
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_SCAN  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_PRE  = CNT_MAX - 1'b1;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_NEURONS - 1);

   state_t                                   r_state;
   state_t                                   w_next_state;
   logic                                     w_accept;
   logic [WINDOW_WIDTH-1:0]                  r_win_cnt;
   logic [NUM_NEURONS-1:0][COUNT_WIDTH-1:0]  r_counts;
   logic [NUM_NEURONS-1:0]                   r_saturated;
   logic [COUNT_WIDTH-1:0]                   r_best;
   logic [INDEX_WIDTH-1:0]                   r_winner_index;
   logic                                     r_any_spike;
   logic [INDEX_WIDTH-1:0]                   r_scan_idx;
   logic [COUNT_WIDTH-1:0]                   w_cur_count;

   assign o_spike_counts = r_counts;
   assign o_saturated    = r_saturated;
   assign o_winner_index = r_winner_index;
   assign o_any_spike    = r_any_spike;
   assign w_cur_count    = r_counts[r_scan_idx];

   // State register; reset aborts any window or scan in progress.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus busy/valid outputs.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      o_busy       = 1'b1;
      o_out_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start && (i_window_length != '0)) begin
               w_accept     = 1'b1;
               w_next_state = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (r_win_cnt == WINDOW_WIDTH'(1)) begin
               w_next_state = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (r_scan_idx == LAST_IDX) begin
               w_next_state = ST_HOLD;
            end
         end
         ST_HOLD: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Datapath: window countdown, saturating counters, running-best scan.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_win_cnt      <= '0;
         r_counts       <= '0;
         r_saturated    <= '0;
         r_best         <= '0;
         r_winner_index <= '0;
         r_any_spike    <= 1'b0;
         r_scan_idx     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_win_cnt      <= i_window_length;
                  r_counts       <= '0;
                  r_saturated    <= '0;
                  r_best         <= '0;
                  r_winner_index <= '0;
                  r_any_spike    <= 1'b0;
                  r_scan_idx     <= '0;
               end
            end
            ST_COUNT: begin
               r_win_cnt <= r_win_cnt - 1'b1;
               for (int i = 0; i < NUM_NEURONS; i++) begin
                  if (i_spike_in[i] && (r_counts[i] != CNT_MAX)) begin
                     r_counts[i] <= r_counts[i] + 1'b1;
                     if (r_counts[i] == CNT_PRE) begin
                        r_saturated[i] <= 1'b1;
                     end
                  end
               end
            end
            ST_SCAN: begin
               // Neuron 0 seeds the best; later neurons win only on a strict
               // increase so ties stay with the lowest index.
               if (r_scan_idx == '0) begin
                  r_best         <= w_cur_count;
                  r_winner_index <= '0;
                  r_any_spike    <= (w_cur_count != '0);
               end else begin
                  if (w_cur_count > r_best) begin
                     r_best         <= w_cur_count;
                     r_winner_index <= r_scan_idx;
                  end
                  r_any_spike <= r_any_spike | (w_cur_count != '0);
               end
               if (r_scan_idx == LAST_IDX) begin
                  r_scan_idx <= '0;
               end else begin
                  r_scan_idx <= r_scan_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
